multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_out_decode.sv | 72 +++++++
 rtl/multicycle_control.sv | 113 +++++++++++
 tb/tb_multicycle_control.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller, its datapath and its bench.
//   state_e   : controller state codes (4 bits; 10-15 unused)
//   op_e      : instruction opcodes
//   alusrcb_e : ALU B-operand select
//   aluop_e   : ALU operation select
//   ctrl_t    : bundle of decoded control outputs
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    OP_RTYPE = 2'b00,
    OP_LW    = 2'b01,
    OP_SW    = 2'b10,
    OP_BEQ   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_SHIMM = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       busy;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// State-to-control decode for the multicycle controller (purely combinational).
//   state_i     : current state code
//   mem_ready_i : memory completion strobe (qualifies IRWrite/PCWrite in FETCH,
//                 InstrDone in MEMWR)
//   zero_i      : ALU zero flag (qualifies PCWrite in BRANCH)
//   clear_i     : abort; zeroes everything except busy
//   ctrl_o      : decoded control bundle
module mc_out_decode
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  input  logic       clear_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o      = '0;
    ctrl_o.busy = (state_i != S_IDLE);
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_SHIMM;
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_source  = 1'b1;
        ctrl_o.pc_write   = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;  // IDLE and unused codes: everything stays 0
    endcase
    // Abort: nothing may commit this cycle; busy still reflects the state.
    if (clear_i) begin
      ctrl_o      = '0;
      ctrl_o.busy = (state_i != S_IDLE);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with retired-instruction counter.
//   clk, rst_n      : clock, synchronous active-low reset
//   Run             : allow fetching; 0 parks in IDLE at the next boundary
//   Clear           : synchronous abort of the current instruction
//   Op, Zero        : opcode, ALU zero flag
//   MemReady        : memory completion for FETCH/MEMRD/MEMWR
//   PCWrite..ALUOp  : datapath controls
//   State, Busy     : current state code, not-IDLE
//   InstrDone       : final-cycle pulse; InstrCount : saturating retire count
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Run,
  input  logic             Clear,
  input  logic [1:0]       Op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic             PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       State,
  output logic             Busy,
  output logic             InstrDone,
  output logic [CNT_W-1:0] InstrCount
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       boundary;
  ctrl_t            ctrl;

  mc_out_decode u_dec (
    .state_i     (state_q),
    .mem_ready_i (MemReady),
    .zero_i      (Zero),
    .clear_i     (Clear),
    .ctrl_o      (ctrl)
  );

  assign boundary = Run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Run) state_d = S_FETCH;
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE: state_d = S_EXEC;
          OP_BEQ:   state_d = S_BRANCH;
          default:  state_d = S_MEMADR;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = boundary;
      S_MEMWR:  if (MemReady) state_d = boundary;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = boundary;
      S_BRANCH: state_d = boundary;
      default:  state_d = S_IDLE;  // recover from unused codes
    endcase
    if (Clear) state_d = S_IDLE;
  end

  // instr_done is already suppressed by Clear inside the decoder.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl.instr_done && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCWrite    = ctrl.pc_write;
  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign PCSource   = ctrl.pc_source;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign Busy       = ctrl.busy;
  assign InstrDone  = ctrl.instr_done;
  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import mc_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0, Run = 1'b0, Clear = 1'b0, Zero = 1'b0, MemReady = 1'b0;
  logic [1:0] Op = 2'b00;
  logic PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic ALUSrcA, PCSource, Busy, InstrDone;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [CNT_W-1:0] InstrCount;
  logic [15:0] obs;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Run(Run), .Clear(Clear), .Op(Op), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .State(State), .Busy(Busy), .InstrDone(InstrDone),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, PCSource, ALUSrcB, ALUOp, Busy, InstrDone};

  typedef struct {
    bit         rst;
    bit         run;
    bit         clr;
    logic [1:0] op;
    bit         zero;
    bit         mr;
    logic [3:0] st;
  } item_t;

  item_t sb[$];
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int cyc = 0;

  // Expected output vector for a state and the inputs that qualify it.
  function automatic logic [15:0] model(logic [3:0] st, bit mr, bit z, bit clr);
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcs, busy, done;
    logic [1:0] asb, aop;
    {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcs, done} = '0;
    asb = 2'b00; aop = 2'b00;
    busy = (st != 4'd0);
    case (st)
      4'd1: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      4'd2: asb = 2'b11;
      4'd3: begin asa = 1; asb = 2'b10; end
      4'd4: begin mrd = 1; iord = 1; end
      4'd5: begin rw = 1; m2r = 1; done = 1; end
      4'd6: begin mwr = 1; iord = 1; done = mr; end
      4'd7: begin asa = 1; aop = 2'b10; end
      4'd8: begin rw = 1; rdst = 1; done = 1; end
      4'd9: begin asa = 1; aop = 2'b01; pcs = 1; pcw = z; done = 1; end
      default: ;
    endcase
    if (clr) begin
      {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcs, done} = '0;
      asb = 2'b00; aop = 2'b00;
    end
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, pcs, asb, aop, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input bit run, input logic [1:0] op, input bit mr, input logic [3:0] st,
                      input bit z = 0, input bit clr = 0, input bit rst = 0);
    item_t it;
    it.run = run; it.op = op; it.mr = mr; it.st = st; it.zero = z; it.clr = clr; it.rst = rst;
    sb.push_back(it);
  endtask

  // Called at a falling edge: per queued cycle, drive inputs, check, advance.
  task automatic drain();
    item_t it;
    logic [15:0] e;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      rst_n = !it.rst; Run = it.run; Clear = it.clr; Op = it.op;
      Zero = it.zero; MemReady = it.mr;
      #1;
      e = model(it.st, it.mr, it.zero, it.clr);
      check($sformatf("state@%0d", cyc), {28'd0, State}, {28'd0, it.st});
      check($sformatf("outputs@%0d", cyc), {16'd0, obs}, {16'd0, e});
      check($sformatf("count@%0d", cyc), {28'd0, InstrCount}, exp_cnt);
      @(negedge clk);
      cyc++;
      if (it.rst) exp_cnt = 0;
      else if (e[0] && exp_cnt < 15) exp_cnt++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state, then R-type (Op changed in EXEC/ALUWB must be ignored)
    push(0, 2'b00, 1, S_IDLE);
    push(1, 2'b00, 1, S_IDLE);
    push(1, 2'b00, 1, S_FETCH);
    push(1, 2'b00, 1, S_DECODE);
    push(1, 2'b11, 1, S_EXEC);
    push(1, 2'b10, 1, S_ALUWB);
    // LW with 3 stall cycles in MEMRD (8 cycles FETCH..MEMWB)
    push(1, 2'b01, 1, S_FETCH);
    push(1, 2'b01, 1, S_DECODE);
    push(1, 2'b01, 1, S_MEMADR);
    push(1, 2'b01, 0, S_MEMRD);
    push(1, 2'b01, 0, S_MEMRD);
    push(1, 2'b01, 0, S_MEMRD);
    push(1, 2'b01, 1, S_MEMRD);
    push(1, 2'b00, 1, S_MEMWB);
    // BEQ taken, then not taken
    push(1, 2'b11, 1, S_FETCH);
    push(1, 2'b11, 1, S_DECODE);
    push(1, 2'b11, 1, S_BRANCH, 1);
    push(1, 2'b11, 1, S_FETCH);
    push(1, 2'b11, 1, S_DECODE);
    push(1, 2'b11, 1, S_BRANCH, 0);
    // SW aborted by Clear in MEMWR (Clear beats Run and MemReady)
    push(1, 2'b10, 1, S_FETCH);
    push(1, 2'b10, 1, S_DECODE);
    push(1, 2'b10, 1, S_MEMADR);
    push(1, 2'b10, 1, S_MEMWR, 0, 1);
    push(0, 2'b10, 1, S_IDLE);
    // SW with stalls in FETCH and MEMWR, Run=0 at boundary
    push(1, 2'b10, 1, S_IDLE);
    push(1, 2'b10, 0, S_FETCH);
    push(1, 2'b10, 1, S_FETCH);
    push(1, 2'b10, 1, S_DECODE);
    push(1, 2'b10, 1, S_MEMADR);
    push(1, 2'b10, 0, S_MEMWR);
    push(0, 2'b10, 1, S_MEMWR);
    push(0, 2'b00, 1, S_IDLE);
    // reset in DECODE discards the instruction and clears the count
    push(1, 2'b00, 1, S_IDLE);
    push(1, 2'b00, 1, S_FETCH);
    push(1, 2'b00, 1, S_DECODE, 0, 0, 1);
    push(0, 2'b00, 1, S_IDLE);
    drain();

    // 17 back-to-back R-types: count saturates at 15, park at last boundary
    push(1, 2'b00, 1, S_IDLE);
    for (int i = 0; i < 17; i++) begin
      push(1, 2'b00, 1, S_FETCH);
      push(1, 2'b00, 1, S_DECODE);
      push(1, 2'b00, 1, S_EXEC);
      push((i < 16), 2'b00, 1, S_ALUWB);
    end
    push(0, 2'b00, 1, S_IDLE);
    drain();
    #1;
    check("sat_count", {28'd0, InstrCount}, 32'd15);
    check("sat_busy", {31'd0, Busy}, 32'd0);

    // unused state code 12: all controls 0, returns to IDLE
    Run = 1'b0; MemReady = 1'b1; Zero = 1'b1;
    @(negedge clk);
    force dut.state_q = 4'd12;
    #1;
    check("forced_state", {28'd0, State}, 32'd12);
    check("forced_outputs", {16'd0, obs}, {16'd0, model(4'd12, 1, 1, 0)});
    release dut.state_q;
    @(negedge clk);
    #1;
    check("recover_state", {28'd0, State}, 32'd0);
    check("recover_count", {28'd0, InstrCount}, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
